cpu_clk_sched: RTL

CPU_CLK_SCHED -- requirements
Module: cpu_clk_sched

---
 rtl/cpu_clk_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/cpu_clk_sched.sv
// cpu_clk_sched
//   Clock-enable scheduler for a single-cycle CPU. Produces one-cycle cpu_ce
//   pulses in free-running (RUN) mode every P = div_ratio clk cycles, or a
//   single pulse per button press (STEP), and can be forced to HALT.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   run_req    level, request free-running enables
//   step_req   debounced step button level, rising edge used
//   halt_req   level, forces and holds HALT
//   div_ratio  enable period in clk cycles (0 behaves as 1)
//   cpu_ce     one-cycle clock-enable pulse
//   step_ack   high in the cycle the step enable is issued
//   state      IDLE=00 RUN=01 STEP=10 HALT=11
//   tick_cnt   number of cpu_ce pulses issued (wraps)
//   brk_en     (CLK_SCHED_BREAK_EN only) break-on-count enable
//   brk_cnt    (CLK_SCHED_BREAK_EN only) tick count that triggers a break
//
// Optional feature: define CLK_SCHED_BREAK_EN to add the brk_en/brk_cnt
// break-to-HALT function.
//
// state | meaning
// IDLE  | no enables, waiting for halt/step/run request
// RUN   | free-running enables every P cycles
// STEP  | single enable pulse with step_ack, then back to IDLE
// HALT  | enables blocked until halt_req and run_req both drop

module cpu_clk_sched #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [DIV_W-1:0] div_ratio,
`ifdef CLK_SCHED_BREAK_EN
  input  logic             brk_en,
  input  logic [15:0]      brk_cnt,
`endif
  output logic             cpu_ce,
  output logic             step_ack,
  output logic [1:0]       state,
  output logic [15:0]      tick_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_t           cur, nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt, last_cnt;
  logic             step_q, step_edge;
  logic             ce_run_q, ce_run_nxt;
  logic             brk_hit;

  assign step_edge = step_req & ~step_q;
  assign last_cnt  = (div_ratio == '0) ? '0 : div_ratio - ONE;

`ifdef CLK_SCHED_BREAK_EN
  // The run pulse currently on cpu_ce is about to be counted; break when
  // that count lands on brk_cnt.
  assign brk_hit = brk_en & ce_run_q & ((tick_cnt + 16'd1) == brk_cnt);
`else
  assign brk_hit = 1'b0;
`endif

  always_comb begin
    nxt        = cur;
    div_nxt    = '0;
    ce_run_nxt = 1'b0;
    case (cur)
      S_IDLE: begin
        if (halt_req)       nxt = S_HALT;
        else if (step_edge) nxt = S_STEP;
        else if (run_req)   nxt = S_RUN;
      end
      S_RUN: begin
        if (halt_req || brk_hit) nxt = S_HALT;
        else if (!run_req)       nxt = S_IDLE;
        else if (div_cnt >= last_cnt) ce_run_nxt = 1'b1;  // >= absorbs a ratio drop mid-count
        else div_nxt = div_cnt + ONE;
      end
      S_STEP: nxt = S_IDLE;
      S_HALT: begin
        if (!halt_req && !run_req) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // step_q keeps sampling during reset so a button already held at
    // release is not seen as a new edge.
    step_q <= step_req;
    if (!rst_n) begin
      cur      <= S_IDLE;
      div_cnt  <= '0;
      ce_run_q <= 1'b0;
      tick_cnt <= '0;
    end else begin
      cur      <= nxt;
      div_cnt  <= div_nxt;
      ce_run_q <= ce_run_nxt;
      tick_cnt <= tick_cnt + {15'd0, cpu_ce};
    end
  end

  assign cpu_ce   = ce_run_q | (cur == S_STEP);
  assign step_ack = (cur == S_STEP);
  assign state    = cur;

endmodule
